// File: rtl/spi_regs_pkg.sv
// Shared constants and types for the SPI register bridge: address map,
// opcode layout, STATUS bit positions and the transaction FSM states.
package spi_regs_pkg;

    localparam logic [6:0] ADDR_ID       = 7'h00;
    localparam logic [6:0] ADDR_LED      = 7'h01;
    localparam logic [6:0] ADDR_COUNT_LO = 7'h02;
    localparam logic [6:0] ADDR_COUNT_HI = 7'h03;
    localparam logic [6:0] ADDR_SCRATCH  = 7'h04;
    localparam logic [6:0] ADDR_STATUS   = 7'h05;

    localparam int WRITE_BIT = 7;

    localparam int ST_BAD_ADDR = 0;
    localparam int ST_TIMEOUT  = 1;
    localparam int ST_RO_WRITE = 2;

    localparam logic [7:0] RESP_IDLE = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RDATA = 2'd2
    } state_t;

endpackage

// File: rtl/txn_timeout.sv
// Restartable down-counter guarding the gap between the two bytes of a
// transaction; expired is high once TIMEOUT idle clocks have been spent.
module txn_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/spi_reg_bridge.sv
// Two-byte SPI read/write protocol decoder driving a small register map
// (ID, LED, scratch, snapshotted encoder count, sticky clear-on-read STATUS).
module spi_reg_bridge
    import spi_regs_pkg::*;
#(
    parameter int         COUNT_WIDTH = 16,
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             cmd,
    input  logic                   cmd_valid,
    input  logic [COUNT_WIDTH-1:0] count_in,
    output logic [7:0]             response,
    output logic [7:0]             led_reg,
    output logic                   busy
);

    state_t      state, state_d;
    logic [6:0]  addr, addr_d;
    logic [7:0]  response_d, led_d, scratch, scratch_d;
    logic [15:0] snap, snap_d;
    logic [2:0]  status, status_d, status_set;
    logic        status_clr;
    logic        expired;

    // Counter reloads throughout IDLE, so each WDATA/RDATA entry starts fresh.
    txn_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .restart (state == IDLE),
        .enable  ((state != IDLE) && !cmd_valid),
        .expired (expired)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state;
        addr_d     = addr;
        response_d = response;
        led_d      = led_reg;
        scratch_d  = scratch;
        snap_d     = snap;
        status_set = '0;
        status_clr = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd[WRITE_BIT]) begin
                        addr_d     = cmd[6:0];
                        response_d = RESP_IDLE;
                        state_d    = WDATA;
                    end else begin
                        state_d = RDATA;
                        case (cmd[6:0])
                            ADDR_ID:       response_d = ID_VALUE;
                            ADDR_LED:      response_d = led_reg;
                            ADDR_COUNT_LO: begin
                                snap_d     = 16'(count_in);
                                response_d = snap_d[7:0];
                            end
                            ADDR_COUNT_HI: response_d = snap[15:8];
                            ADDR_SCRATCH:  response_d = scratch;
                            ADDR_STATUS: begin
                                response_d = {5'b0, status};
                                status_clr = 1'b1;
                            end
                            default: begin
                                response_d              = 8'hFF;
                                status_set[ST_BAD_ADDR] = 1'b1;
                            end
                        endcase
                    end
                end
            end

            WDATA: begin
                if (cmd_valid) begin
                    state_d    = IDLE;
                    response_d = RESP_IDLE;
                    case (addr)
                        ADDR_LED:     led_d     = cmd;
                        ADDR_SCRATCH: scratch_d = cmd;
                        ADDR_ID, ADDR_COUNT_LO, ADDR_COUNT_HI, ADDR_STATUS:
                            status_set[ST_RO_WRITE] = 1'b1;
                        default:      status_set[ST_BAD_ADDR] = 1'b1;
                    endcase
                end else if (expired) begin
                    status_set[ST_TIMEOUT] = 1'b1;
                    response_d             = RESP_IDLE;
                    state_d                = IDLE;
                end
            end

            RDATA: begin
                if (cmd_valid || expired) begin
                    status_set[ST_TIMEOUT] = !cmd_valid;
                    response_d             = RESP_IDLE;
                    state_d                = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Set wins over a same-cycle clear-on-read.
        status_d = (status & ~{3{status_clr}}) | status_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            response <= RESP_IDLE;
            led_reg  <= '0;
            scratch  <= '0;
            snap     <= '0;
            status   <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            addr     <= addr_d;
            response <= response_d;
            led_reg  <= led_d;
            scratch  <= scratch_d;
            snap     <= snap_d;
            status   <= status_d;
            busy     <= (state_d != IDLE);
        end
    end

endmodule
